// File: rtl/score_record_if.sv
// score_record_if: round-result inputs and record outputs of the prime-game
// record keeper. The master drives the round result, the slave (score_record)
// returns the high score, the winner, the personal best and the event pulses.
interface score_record_if #(
  parameter int SCORE_W = 7
);
  logic               game_timeout;
  logic [SCORE_W-1:0] Current_Score;
  logic [2:0]         player_id;
  logic [SCORE_W-1:0] Highest_Score;
  logic [2:0]         Player_Won;
  logic [SCORE_W-1:0] Personel_Best;
  logic               new_record;
  logic               new_pb;
  logic               id_err;

  modport master (
    output game_timeout, Current_Score, player_id,
    input  Highest_Score, Player_Won, Personel_Best, new_record, new_pb, id_err
  );

  modport slave (
    input  game_timeout, Current_Score, player_id,
    output Highest_Score, Player_Won, Personel_Best, new_record, new_pb, id_err
  );
endinterface

// File: rtl/score_record.sv
// score_record: commits one round result per rising edge of game_timeout into
// a per-player personal-best table and the all-time high score.
// Sequence IDLE (latch) -> CAPTURE (compare) -> CHECK (commit) -> WAIT.
// Optional feature macro RECORD_CLEAR_EN adds a synchronous clear_records input.
module score_record #(
  parameter int NUM_PLAYERS = 8,
  parameter int SCORE_W     = 7,
  parameter int MAX_SCORE   = 99
) (
  input  logic clk,
  input  logic reset,
`ifdef RECORD_CLEAR_EN
  input  logic clear_records,
`endif
  score_record_if.slave bus
);

  localparam logic [SCORE_W-1:0] MAX_S = SCORE_W'(MAX_SCORE);
  localparam logic [3:0]         NP    = 4'(NUM_PLAYERS);

  typedef enum logic [1:0] {IDLE, CAPTURE, CHECK, WAIT} state_t;

  state_t             state, state_next;
  logic               timeout_q;
  logic               rise;
  logic [SCORE_W-1:0] s_in;
  logic [SCORE_W-1:0] s_q;
  logic [2:0]         p_q;
  logic               p_ok;
  logic               rd_ok;
  logic               gt_pb, gt_hi;
  logic [SCORE_W-1:0] pb [NUM_PLAYERS];
  logic [SCORE_W-1:0] hi_score;
  logic [2:0]         won;
  logic [SCORE_W-1:0] pb_rd;
  logic               nr_pulse, npb_pulse, ie_pulse;
  logic               clr;

`ifdef RECORD_CLEAR_EN
  assign clr = clear_records;
`else
  assign clr = 1'b0;
`endif

  assign rise  = bus.game_timeout & ~timeout_q;
  assign s_in  = (bus.Current_Score > MAX_S) ? MAX_S : bus.Current_Score;
  assign p_ok  = ({1'b0, p_q} < NP);
  assign rd_ok = ({1'b0, bus.player_id} < NP);

  // Next-state logic; a clear forces WAIT so no half-finished commit survives
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rise) state_next = CAPTURE;
      CAPTURE: state_next = p_ok ? CHECK : WAIT;
      CHECK:   state_next = WAIT;
      WAIT:    if (!bus.game_timeout) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clr) state_next = WAIT;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Edge detector history for game_timeout
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) timeout_q <= 1'b0;
    else        timeout_q <= bus.game_timeout;
  end

  // Round datapath: latch, compare, commit, and the registered pb read port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) pb[i] <= '0;
      s_q       <= '0;
      p_q       <= '0;
      gt_pb     <= 1'b0;
      gt_hi     <= 1'b0;
      hi_score  <= '0;
      won       <= '0;
      pb_rd     <= '0;
      nr_pulse  <= 1'b0;
      npb_pulse <= 1'b0;
      ie_pulse  <= 1'b0;
    end else begin
      nr_pulse  <= 1'b0;
      npb_pulse <= 1'b0;
      ie_pulse  <= 1'b0;
      if (clr) begin
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) pb[i] <= '0;
        hi_score <= '0;
        won      <= '0;
        pb_rd    <= '0;
      end else begin
        pb_rd <= rd_ok ? pb[bus.player_id] : '0;
        case (state)
          IDLE: begin
            if (rise) begin
              s_q <= s_in;
              p_q <= bus.player_id;
            end
          end
          CAPTURE: begin
            if (!p_ok) begin
              ie_pulse <= 1'b1;
            end else begin
              gt_pb <= (s_q > pb[p_q]);
              gt_hi <= (s_q > hi_score);
            end
          end
          CHECK: begin
            if (gt_pb) begin
              pb[p_q]   <= s_q;
              npb_pulse <= 1'b1;
            end
            if (gt_hi) begin
              hi_score <= s_q;
              won      <= p_q;
              nr_pulse <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.Highest_Score = hi_score;
  assign bus.Player_Won    = won;
  assign bus.Personel_Best = pb_rd;
  assign bus.new_record    = nr_pulse;
  assign bus.new_pb        = npb_pulse;
  assign bus.id_err        = ie_pulse;

endmodule
